// File: rtl/dmem_pkg.sv
// dmem_pkg: constants and FSM state encoding shared by the data-side
// main-memory responder and the cache controller that talks to it.
package dmem_pkg;

  localparam int DMEM_BLOCK_ADDR_W = 16;
  localparam int DMEM_BLOCK_BITS   = 128;
  localparam int DMEM_DEPTH_W      = 10;
  localparam int DMEM_READ_LAT     = 10;
  localparam int DMEM_WRITE_LAT    = 10;

  // Latency counter width; comfortably covers any practical latency setting.
  localparam int DMEM_CNT_W = 16;

  typedef logic [2:0] dmem_state_t;

  localparam dmem_state_t ST_IDLE    = 3'd0;
  localparam dmem_state_t ST_RD_WAIT = 3'd1;
  localparam dmem_state_t ST_WR_WAIT = 3'd2;
  localparam dmem_state_t ST_RD_DONE = 3'd3;
  localparam dmem_state_t ST_WR_DONE = 3'd4;

  // Value loaded into the latency counter at acceptance so that the
  // response rises exactly lat edges after the request is sampled.
  function automatic logic [DMEM_CNT_W-1:0] lat_load(input int lat);
    return DMEM_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_block_array.sv
// dmem_block_array: single-port synchronous block RAM with one write
// enable, one read enable and a registered read-data output.
module dmem_block_array #(
  parameter int DEPTH_W    = 10,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_W-1:0]    addr,
  input  logic [BLOCK_BITS-1:0] wdata,
  output logic [BLOCK_BITS-1:0] rdata
);

  logic [BLOCK_BITS-1:0] mem_q [2**DEPTH_W];
  logic [BLOCK_BITS-1:0] rdata_q;
  logic [BLOCK_BITS-1:0] rdata_d;

  // Storage is never cleared by reset so preloaded contents survive it.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read data only changes on a read strobe, otherwise the last block is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  // Read-data register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_block_responder.sv
// dmem_block_responder: block-granular main-memory model on the data side.
// Accepts one block read or write at a time, waits a programmable latency,
// then answers with a four-phase level handshake.
module dmem_block_responder
  import dmem_pkg::*;
#(
  parameter int BLOCK_ADDR_W = DMEM_BLOCK_ADDR_W,
  parameter int BLOCK_BITS   = DMEM_BLOCK_BITS,
  parameter int DEPTH_W      = DMEM_DEPTH_W,
  parameter int READ_LAT     = DMEM_READ_LAT,
  parameter int WRITE_LAT    = DMEM_WRITE_LAT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    memRen,
  input  logic                    memWen,
  input  logic [BLOCK_ADDR_W-1:0] BlockAddr,
  input  logic [BLOCK_BITS-1:0]   memDin,
  output logic                    memReadReady,
  output logic                    memWriteDone,
  output logic [BLOCK_BITS-1:0]   memDout
);

  dmem_state_t           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH_W-1:0]    idx_q, idx_d;
  logic [BLOCK_BITS-1:0] din_q, din_d;
  logic                  read_ready_q, read_ready_d;
  logic                  write_done_q, write_done_d;
  logic                  arr_we, arr_re;

  // Address bits above the array index are deliberately ignored (aliasing).
  if (BLOCK_ADDR_W > DEPTH_W) begin : g_addr_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^BlockAddr[BLOCK_ADDR_W-1:DEPTH_W];
  end

  // Next-state logic: acceptance, latency countdown, commit/read strobes and
  // holding the response until the matching request is seen low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    din_d   = din_q;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memWen) begin
          state_d = ST_WR_WAIT;
          idx_d   = BlockAddr[DEPTH_W-1:0];
          din_d   = memDin;
          cnt_d   = lat_load(WRITE_LAT);
        end else if (memRen) begin
          state_d = ST_RD_WAIT;
          idx_d   = BlockAddr[DEPTH_W-1:0];
          cnt_d   = lat_load(READ_LAT);
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_DONE;
          arr_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_DONE;
          arr_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      ST_RD_DONE: begin
        if (!memRen) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_DONE: begin
        if (!memWen) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    read_ready_d = (state_d == ST_RD_DONE);
    write_done_d = (state_d == ST_WR_DONE);
  end

  // Control and capture registers; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      din_q        <= '0;
      read_ready_q <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      din_q        <= din_d;
      read_ready_q <= read_ready_d;
      write_done_q <= write_done_d;
    end
  end

  // Strobes are masked by reset so a write landing on a reset edge is dropped.
  dmem_block_array #(
    .DEPTH_W    (DEPTH_W),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (arr_we && !reset),
    .re    (arr_re && !reset),
    .addr  (idx_q),
    .wdata (din_q),
    .rdata (memDout)
  );

  assign memReadReady = read_ready_q;
  assign memWriteDone = write_done_q;

endmodule

// File: tb/tb_dmem_block_responder.sv
// tb_dmem_block_responder: directed scenarios for the block responder with a
// queue of expected read blocks consumed whenever a read response appears.
module tb_dmem_block_responder;
  import dmem_pkg::*;

  localparam int LAT = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic         memRen;
  logic         memWen;
  logic [15:0]  BlockAddr;
  logic [127:0] memDin;
  logic         memReadReady;
  logic         memWriteDone;
  logic [127:0] memDout;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [127:0] exp_q[$];

  always #5 clock = ~clock;

  dmem_block_responder #(
    .BLOCK_ADDR_W (16),
    .BLOCK_BITS   (128),
    .DEPTH_W      (10),
    .READ_LAT     (LAT),
    .WRITE_LAT    (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .memRen       (memRen),
    .memWen       (memWen),
    .BlockAddr    (BlockAddr),
    .memDin       (memDin),
    .memReadReady (memReadReady),
    .memWriteDone (memWriteDone),
    .memDout      (memDout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [127:0] d, output bit ok);
    ok        = 1'b0;
    BlockAddr = a;
    memDin    = d;
    memWen    = 1'b1;
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      if (memWriteDone) begin
        ok = 1'b1;
        break;
      end
    end
    memWen = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [15:0] a, output bit ok, output logic [127:0] d);
    ok        = 1'b0;
    d         = '0;
    BlockAddr = a;
    memRen    = 1'b1;
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      if (memReadReady) begin
        ok = 1'b1;
        d  = memDout;
        break;
      end
    end
    memRen = 1'b0;
    tick();
  endtask

  task automatic check_pop(input string name, input logic [127:0] got);
    logic [127:0] exp;
    checks_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %h but scoreboard empty", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; memRen = 1'b0; memWen = 1'b0; BlockAddr = '0; memDin = '0;
    tick();
    tick();
    checks_total++;
    if (memReadReady !== 1'b0) $display("FAIL reset_ready: got %b expected 0", memReadReady);
    else checks_passed++;
    checks_total++;
    if (memWriteDone !== 1'b0) $display("FAIL reset_done: got %b expected 0", memWriteDone);
    else checks_passed++;
    checks_total++;
    if (memDout !== 128'h0) $display("FAIL reset_dout: got %h expected 0", memDout);
    else checks_passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_latency();
    bit early = 1'b0;
    bit dropped = 1'b0;
    BlockAddr = 16'h0041;
    memDin    = {32{4'hA}};
    memWen    = 1'b1;
    tick();
    for (int k = 1; k < LAT; k++) begin
      tick();
      if (memWriteDone) early = 1'b1;
    end
    checks_total++;
    if (early !== 1'b0) $display("FAIL write_early: got %b expected 0", early);
    else checks_passed++;
    tick();
    checks_total++;
    if (memWriteDone !== 1'b1) $display("FAIL write_at_lat: got %b expected 1", memWriteDone);
    else checks_passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!memWriteDone) dropped = 1'b1;
    end
    checks_total++;
    if (dropped !== 1'b0) $display("FAIL write_hold: got %b expected 0", dropped);
    else checks_passed++;
    memWen = 1'b0;
    tick();
    checks_total++;
    if (memWriteDone !== 1'b0) $display("FAIL write_fall: got %b expected 0", memWriteDone);
    else checks_passed++;
  endtask

  task automatic test_read_latency();
    bit early = 1'b0;
    exp_q.push_back({32{4'hA}});
    BlockAddr = 16'h0041;
    memRen    = 1'b1;
    tick();
    for (int k = 1; k < LAT; k++) begin
      tick();
      if (k == 3) BlockAddr = 16'h0000;
      if (memReadReady) early = 1'b1;
    end
    checks_total++;
    if (early !== 1'b0) $display("FAIL read_early: got %b expected 0", early);
    else checks_passed++;
    tick();
    checks_total++;
    if (memReadReady !== 1'b1) $display("FAIL read_at_lat: got %b expected 1", memReadReady);
    else checks_passed++;
    check_pop("read_data", memDout);
    memRen = 1'b0;
    tick();
    checks_total++;
    if (memReadReady !== 1'b0) $display("FAIL read_fall: got %b expected 0", memReadReady);
    else checks_passed++;
    checks_total++;
    if (memDout !== {32{4'hA}}) $display("FAIL read_dout_hold: got %h expected %h", memDout, {32{4'hA}});
    else checks_passed++;
  endtask

  task automatic test_both_requests();
    bit saw_done = 1'b0;
    bit saw_ready = 1'b0;
    exp_q.push_back({8{16'hFF00}});
    BlockAddr = 16'h00F0;
    memDin    = {8{16'hFF00}};
    memWen    = 1'b1;
    memRen    = 1'b1;
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      if (memReadReady) saw_ready = 1'b1;
      if (memWriteDone) begin
        saw_done = 1'b1;
        break;
      end
    end
    checks_total++;
    if (saw_done !== 1'b1) $display("FAIL both_write_first: got %b expected 1", saw_done);
    else checks_passed++;
    checks_total++;
    if (saw_ready !== 1'b0) $display("FAIL both_no_early_read: got %b expected 0", saw_ready);
    else checks_passed++;
    memWen    = 1'b0;
    saw_ready = 1'b0;
    for (int n = 0; n < 2 * LAT + 6; n++) begin
      tick();
      if (memReadReady) begin
        saw_ready = 1'b1;
        break;
      end
    end
    checks_total++;
    if (saw_ready !== 1'b1) $display("FAIL both_read_after: got %b expected 1", saw_ready);
    else checks_passed++;
    check_pop("both_read_data", memDout);
    memRen = 1'b0;
    tick();
  endtask

  task automatic test_drop_request();
    bit early = 1'b0;
    exp_q.push_back({8{16'hFF00}});
    BlockAddr = 16'h00F0;
    memRen    = 1'b1;
    tick();
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k == 3) memRen = 1'b0;
      if (k < LAT && memReadReady) early = 1'b1;
      if (k == LAT) begin
        checks_total++;
        if (memReadReady !== 1'b1) $display("FAIL drop_pulse: got %b expected 1", memReadReady);
        else checks_passed++;
        check_pop("drop_data", memDout);
      end
      if (k == LAT + 1) begin
        checks_total++;
        if (memReadReady !== 1'b0) $display("FAIL drop_pulse_len: got %b expected 0", memReadReady);
        else checks_passed++;
      end
      if (k == LAT + 2) begin
        checks_total++;
        if (dut.state_q !== ST_IDLE) $display("FAIL drop_idle: got %0d expected %0d", dut.state_q, ST_IDLE);
        else checks_passed++;
      end
    end
    checks_total++;
    if (early !== 1'b0) $display("FAIL drop_early: got %b expected 0", early);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit seen = 1'b0;
    logic [127:0] rd;
    logic [127:0] old_blk = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    do_write(16'h0123, old_blk, ok);
    checks_total++;
    if (ok !== 1'b1) $display("FAIL rst_preload: got %b expected 1", ok);
    else checks_passed++;
    BlockAddr = 16'h0123;
    memDin    = {16{8'h5A}};
    memWen    = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    reset  = 1'b1;
    memWen = 1'b0;
    tick();
    checks_total++;
    if (memWriteDone !== 1'b0) $display("FAIL rst_done: got %b expected 0", memWriteDone);
    else checks_passed++;
    checks_total++;
    if (memDout !== 128'h0) $display("FAIL rst_dout: got %h expected 0", memDout);
    else checks_passed++;
    reset = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (memWriteDone) seen = 1'b1;
    end
    checks_total++;
    if (seen !== 1'b0) $display("FAIL rst_no_done: got %b expected 0", seen);
    else checks_passed++;
    exp_q.push_back(old_blk);
    do_read(16'h0123, ok, rd);
    checks_total++;
    if (ok !== 1'b1) $display("FAIL rst_read_resp: got %b expected 1", ok);
    else checks_passed++;
    check_pop("rst_old_data", rd);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [127:0] rd;
    logic [127:0] blk = {4{32'hC0DE_0401}};
    do_write(16'h0401, blk, ok);
    checks_total++;
    if (ok !== 1'b1) $display("FAIL wrap_write: got %b expected 1", ok);
    else checks_passed++;
    exp_q.push_back(blk);
    do_read(16'h0001, ok, rd);
    checks_total++;
    if (ok !== 1'b1) $display("FAIL wrap_read_resp: got %b expected 1", ok);
    else checks_passed++;
    check_pop("wrap_data", rd);
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_latency();
    test_both_requests();
    test_drop_request();
    test_reset_mid_write();
    test_wrap();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", checks_passed, checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
